pc_redirect_ctrl: RTL and testbench

Sequences the control-flow redirect that follows branch/jump resolution in execute. Captures the resolved target when execute asserts x_pc_select, flushes the wrong-path instructions in fetch/decode and decode/execute, and holds the redirect until fetch accepts it. It then masks the wrong-path fetch shadow for a programmable number of cycles. It sits between the execute-stage branch logic and the fetch/PC register and hazard unit.

---
 rtl/pc_redirect_ctrl.sv | 109 ++++++++++
 tb/tb_pc_redirect_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// Control-flow redirect sequencer: captures the execute-stage target, flushes
// wrong-path stages, holds the redirect for fetch, then masks the fetch shadow.
// Optional redirect statistics counters are enabled by defining BRANCH_STATS_EN.
module pc_redirect_ctrl #(
  parameter int SHADOW = 1,
  parameter int XLEN   = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            x_valid,
  input  logic            x_pc_select,
  input  logic [XLEN-1:0] x_target,
  input  logic            d_stall,
  input  logic            f_stall,
  output logic            f_redirect,
  output logic [XLEN-1:0] f_redirect_pc,
  output logic            flush_fd,
  output logic            flush_dx,
  output logic            busy,
  output logic            proto_err,
  output logic [31:0]     stat_redirects,
  output logic [31:0]     stat_wait_cycles
);

  typedef enum logic [1:0] {IDLE, ISSUE, SHDW} state_t;

  localparam logic [3:0] SHADOW_LD = 4'(SHADOW);

  state_t     state;
  logic [3:0] shadow_cnt;
  logic       resolve;
  logic       acc;

  assign resolve = x_valid & x_pc_select;
  assign acc     = (state == IDLE) & resolve & ~d_stall;

  // NOTE: flush on the accept cycle is combinational so the wrong-path
  // instructions already in IF/ID and ID/EX are squashed at the same edge.
  assign flush_fd   = acc | (state != IDLE);
  assign flush_dx   = acc;
  assign f_redirect = (state == ISSUE);
  assign busy       = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      shadow_cnt    <= '0;
      f_redirect_pc <= '0;
      proto_err     <= 1'b0;
    end else begin
      if ((state != IDLE) && resolve)
        proto_err <= 1'b1;
      case (state)
        IDLE: begin
          if (acc) begin
            f_redirect_pc <= x_target & ~XLEN'(1);
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (!f_stall) begin
            if (SHADOW_LD != 4'd0) begin
              shadow_cnt <= SHADOW_LD;
              state      <= SHDW;
            end else begin
              state <= IDLE;
            end
          end
        end
        SHDW: begin
          if (shadow_cnt <= 4'd1) begin
            shadow_cnt <= '0;
            state      <= IDLE;
          end else begin
            shadow_cnt <= shadow_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] redirects_q;
  logic [31:0] wait_q;

  // Both counters saturate instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redirects_q <= '0;
      wait_q      <= '0;
    end else if (state == ISSUE) begin
      if (!f_stall && (redirects_q != 32'hFFFF_FFFF))
        redirects_q <= redirects_q + 32'd1;
      if (f_stall && (wait_q != 32'hFFFF_FFFF))
        wait_q <= wait_q + 32'd1;
    end
  end

  assign stat_redirects   = redirects_q;
  assign stat_wait_cycles = wait_q;
`else
  assign stat_redirects   = 32'd0;
  assign stat_wait_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: three instances (SHADOW=1, 0, 3)
// share stimulus; per-cycle expected outputs are queued and checked at negedge.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        x_valid, x_pc_select, d_stall, f_stall;
  logic [31:0] x_target;

  logic        red1, red0, red3;
  logic [31:0] pc1, pc0, pc3;
  logic        ffd1, ffd0, ffd3, fdx1, fdx0, fdx3;
  logic        busy1, busy0, busy3, perr1, perr0, perr3;
  logic [31:0] sr1, sr0, sr3, sw1, sw0, sw3;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        red;
    logic [31:0] pc;
    logic        ffd1, fdx, busy1, ffd0, busy0, ffd3, busy3;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_pc = 32'd0;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.SHADOW(1), .XLEN(32)) u1 (
    .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x_pc_select(x_pc_select),
    .x_target(x_target), .d_stall(d_stall), .f_stall(f_stall),
    .f_redirect(red1), .f_redirect_pc(pc1), .flush_fd(ffd1), .flush_dx(fdx1),
    .busy(busy1), .proto_err(perr1), .stat_redirects(sr1), .stat_wait_cycles(sw1));

  pc_redirect_ctrl #(.SHADOW(0), .XLEN(32)) u0 (
    .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x_pc_select(x_pc_select),
    .x_target(x_target), .d_stall(d_stall), .f_stall(f_stall),
    .f_redirect(red0), .f_redirect_pc(pc0), .flush_fd(ffd0), .flush_dx(fdx0),
    .busy(busy0), .proto_err(perr0), .stat_redirects(sr0), .stat_wait_cycles(sw0));

  pc_redirect_ctrl #(.SHADOW(3), .XLEN(32)) u3 (
    .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x_pc_select(x_pc_select),
    .x_target(x_target), .d_stall(d_stall), .f_stall(f_stall),
    .f_redirect(red3), .f_redirect_pc(pc3), .flush_fd(ffd3), .flush_dx(fdx3),
    .busy(busy3), .proto_err(perr3), .stat_redirects(sr3), .stat_wait_cycles(sw3));

  function automatic exp_t mk(input logic red, f1, dx, b1, f0, b0, f3, b3);
    exp_t e;
    e.red = red; e.pc = exp_pc; e.ffd1 = f1; e.fdx = dx; e.busy1 = b1;
    e.ffd0 = f0; e.busy0 = b0; e.ffd3 = f3; e.busy3 = b3;
    return e;
  endfunction

  // Scoreboard drain: one expected entry per driven cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      exp_t a;
      e = sb.pop_front();
      a.red = red1; a.pc = pc1; a.ffd1 = ffd1; a.fdx = fdx1; a.busy1 = busy1;
      a.ffd0 = ffd0; a.busy0 = busy0; a.ffd3 = ffd3; a.busy3 = busy3;
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL cycle_outputs t=%0t actual red=%b pc=%h ffd1=%b fdx=%b busy1=%b ffd0=%b busy0=%b ffd3=%b busy3=%b required red=%b pc=%h ffd1=%b fdx=%b busy1=%b ffd0=%b busy0=%b ffd3=%b busy3=%b",
                 $time, a.red, a.pc, a.ffd1, a.fdx, a.busy1, a.ffd0, a.busy0, a.ffd3, a.busy3,
                 e.red, e.pc, e.ffd1, e.fdx, e.busy1, e.ffd0, e.busy0, e.ffd3, e.busy3);
      end
      if ((red0 !== red1) || (red3 !== red1) || (pc0 !== pc1) || (pc3 !== pc1) ||
          (fdx0 !== e.fdx) || (fdx3 !== e.fdx)) begin
        miscompares++;
        $display("FAIL variant_outputs t=%0t actual red0=%b red3=%b pc0=%h pc3=%h fdx0=%b fdx3=%b required red=%b pc=%h fdx=%b",
                 $time, red0, red3, pc0, pc3, fdx0, fdx3, e.red, e.pc, e.fdx);
      end
    end
  end

  task automatic cyc(input logic v, sel, input logic [31:0] tgt,
                     input logic ds, fs, rst, input exp_t e, input logic push);
    @(posedge clk);
    #1;
    x_valid = v; x_pc_select = sel; x_target = tgt;
    d_stall = ds; f_stall = fs; rst_n = rst;
    if (push) sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(0, 0, 32'h0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0), 1);
  endtask

  task automatic check_side(input string name, input logic perr, input logic [31:0] r, w);
    @(negedge clk);
    vectors++;
    if ({perr1, perr0, perr3} !== {3{perr}}) begin
      miscompares++;
      $display("FAIL %s_proto_err actual %b%b%b required %b", name, perr1, perr0, perr3, perr);
    end
    vectors++;
    if ({sr1, sw1} !== {r, w}) begin
      miscompares++;
      $display("FAIL %s_stats actual redirects=%0d wait=%0d required redirects=%0d wait=%0d",
               name, sr1, sw1, r, w);
    end
  endtask

  task automatic test_reset;
    cyc(0, 0, 32'h0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0), 0);
    cyc(0, 0, 32'h0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0), 1);
    idle(2);
    check_side("reset", 1'b0, 32'd0, 32'd0);
  endtask

  // Accept cycle expectations shared by every scenario: flush on both stages.
  task automatic accept(input logic [31:0] tgt, input logic fs);
    cyc(1, 1, tgt, 0, fs, 1, mk(0, 1, 1, 0, 1, 0, 1, 0), 1);
    exp_pc = {tgt[31:1], 1'b0};
  endtask

  task automatic tail_after_consume;
    cyc(0, 0, 32'h0, 0, 0, 1, mk(0, 1, 0, 1, 0, 0, 1, 1), 1);
    cyc(0, 0, 32'h0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 1, 1), 1);
    cyc(0, 0, 32'h0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 1, 1), 1);
    idle(2);
  endtask

  task automatic test_basic;
    accept(32'h0000_1003, 0);
    cyc(0, 0, 32'h0, 0, 0, 1, mk(1, 1, 0, 1, 1, 1, 1, 1), 1);
    tail_after_consume();
  endtask

  task automatic test_backpressure;
    accept(32'h0000_4001, 0);
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 32'h0, 0, 1, 1, mk(1, 1, 0, 1, 1, 1, 1, 1), 1);
    cyc(0, 0, 32'h0, 0, 0, 1, mk(1, 1, 0, 1, 1, 1, 1, 1), 1);
    tail_after_consume();
`ifdef BRANCH_STATS_EN
    check_side("backpressure", 1'b0, 32'd2, 32'd3);
`else
    check_side("backpressure", 1'b0, 32'd0, 32'd0);
`endif
  endtask

  task automatic test_hazard;
    for (int i = 0; i < 2; i++)
      cyc(1, 1, 32'h0000_0101, 1, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0), 1);
    cyc(0, 1, 32'h0000_0101, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0), 1);
    accept(32'h0000_0101, 0);
    cyc(0, 0, 32'h0, 1, 0, 1, mk(1, 1, 0, 1, 1, 1, 1, 1), 1);
    tail_after_consume();
  endtask

  task automatic test_proto;
    accept(32'h0000_3000, 0);
    cyc(1, 1, 32'h0000_2000, 0, 1, 1, mk(1, 1, 0, 1, 1, 1, 1, 1), 1);
    cyc(0, 0, 32'h0, 0, 0, 1, mk(1, 1, 0, 1, 1, 1, 1, 1), 1);
    tail_after_consume();
`ifdef BRANCH_STATS_EN
    check_side("proto_sticky", 1'b1, 32'd4, 32'd4);
`else
    check_side("proto_sticky", 1'b1, 32'd0, 32'd0);
`endif
  endtask

  task automatic test_reset_mid_issue;
    accept(32'h0000_5005, 0);
    cyc(0, 0, 32'h0, 0, 1, 1, mk(1, 1, 0, 1, 1, 1, 1, 1), 1);
    cyc(0, 0, 32'h0, 0, 1, 0, mk(1, 1, 0, 1, 1, 1, 1, 1), 1);
    exp_pc = 32'd0;
    cyc(0, 0, 32'h0, 0, 1, 1, mk(0, 0, 0, 0, 0, 0, 0, 0), 1);
    cyc(0, 0, 32'h0, 0, 1, 1, mk(0, 0, 0, 0, 0, 0, 0, 0), 1);
    idle(3);
    check_side("reset_mid_issue", 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; x_valid = 1'b0; x_pc_select = 1'b0;
    x_target = 32'h0; d_stall = 1'b0; f_stall = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_hazard();
    test_proto();
    test_reset_mid_issue();
    @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain actual %0d left required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
